// File: rtl/issue_control_pkg.sv
// Shared types for the dual-issue scheduler: unit codes, pipe selects,
// the held slot descriptor and the unit latency lookup.
package issue_control_pkg;
  typedef enum logic [1:0] {EU_FP = 2'd0, EU_FX2 = 2'd1, EU_BYTE = 2'd2, EU_FX1 = 2'd3} even_unit_e;
  typedef enum logic [1:0] {OU_PERM = 2'd0, OU_LS = 2'd1, OU_BR = 2'd2, OU_NONE = 2'd3} odd_unit_e;

  localparam logic PIPE_EVEN = 1'b0;
  localparam logic PIPE_ODD  = 1'b1;
  localparam int   NUM_REGS  = 128;
  localparam int   CNT_W     = 3;

  typedef struct packed {
    logic            pipe;
    logic [1:0]      unit;
    logic [6:0]      rt;
    logic            reg_write;
    logic [2:0][6:0] src;
    logic [2:0]      src_use;
  } slot_t;

  // Indexed by {pipe, unit}: entries 0..3 even pipe, 4..7 odd pipe.
  typedef logic [7:0][3:0] lat_tab_t;

  function automatic logic [3:0] unit_lat(logic pipe, logic [1:0] unit, lat_tab_t tab);
    return tab[{pipe, unit}];
  endfunction
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register countdown of in-flight results; reports per-slot readiness
// (all used sources and the destination idle).
module reg_scoreboard
  import issue_control_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            ld_en,
  input  logic [1:0][6:0]       ld_rt,
  input  logic [1:0][CNT_W-1:0] ld_cnt,
  input  logic [1:0][2:0][6:0]  rd_src,
  input  logic [1:0][2:0]       rd_use,
  input  logic [1:0][6:0]       rd_rt,
  input  logic [1:0]            rd_wr,
  output logic [1:0]            slot_ok
);
  logic [CNT_W-1:0] cnt [NUM_REGS];

  // A load replaces that entry's decrement in the same cycle.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++) begin
      if (reset)                             cnt[r] <= '0;
      else if (ld_en[1] && ld_rt[1] == 7'(r)) cnt[r] <= ld_cnt[1];
      else if (ld_en[0] && ld_rt[0] == 7'(r)) cnt[r] <= ld_cnt[0];
      else if (cnt[r] != '0)                 cnt[r] <= cnt[r] - 1'b1;
    end
  end

  always_comb begin
    slot_ok = '1;
    for (int s = 0; s < 2; s++) begin
      if (rd_wr[s] && cnt[rd_rt[s]] != '0) slot_ok[s] = 1'b0;
      for (int k = 0; k < 3; k++)
        if (rd_use[s][k] && cnt[rd_src[s][k]] != '0) slot_ok[s] = 1'b0;
    end
  end
endmodule

// File: rtl/issue_control.sv
// Holds one decoded pair and steers its slots to the even/odd pipes,
// dual-issuing when hazard-free and otherwise issuing in program order.
module issue_control
  import issue_control_pkg::*;
#(
  parameter int LAT_FP   = 6,
  parameter int LAT_FX2  = 4,
  parameter int LAT_BYTE = 4,
  parameter int LAT_FX1  = 2,
  parameter int LAT_PERM = 4,
  parameter int LAT_LS   = 6,
  parameter int LAT_BR   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pair_valid,
  output logic                 pair_ready,
  input  logic [1:0]           slot_valid,
  input  logic [1:0]           slot_pipe,
  input  logic [1:0][1:0]      slot_unit,
  input  logic [1:0][6:0]      slot_rt,
  input  logic [1:0]           slot_reg_write,
  input  logic [1:0][2:0][6:0] slot_src,
  input  logic [1:0][2:0]      slot_src_use,
  input  logic                 flush,
  output logic                 issue_even,
  output logic                 even_sel,
  output logic                 issue_odd,
  output logic                 odd_sel,
  output logic                 first_odd,
  output logic                 stall
);
  localparam lat_tab_t LAT_TAB = {4'(LAT_BR), 4'(LAT_BR), 4'(LAT_LS), 4'(LAT_PERM),
                                  4'(LAT_FX1), 4'(LAT_BYTE), 4'(LAT_FX2), 4'(LAT_FP)};

  // State is the pending-slot mask itself.
  typedef enum logic [1:0] {ST_EMPTY = 2'b00, ST_ONLY0 = 2'b01, ST_ONLY1 = 2'b10, ST_BOTH = 2'b11} pend_e;

  pend_e                 state, state_nxt;
  slot_t [1:0]           held;
  logic  [1:0]           ready, iss, ld_en;
  logic  [1:0][CNT_W-1:0] ld_cnt;
  logic                  raw, waw, dual, accept;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_EMPTY;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (accept)
      for (int s = 0; s < 2; s++)
        held[s] <= '{pipe: slot_pipe[s], unit: slot_unit[s], rt: slot_rt[s],
                     reg_write: slot_reg_write[s], src: slot_src[s], src_use: slot_src_use[s]};
  end

  always_comb begin
    raw = 1'b0;
    for (int k = 0; k < 3; k++)
      if (held[1].src_use[k] && held[1].src[k] == held[0].rt) raw = held[0].reg_write;
    waw  = held[0].reg_write && held[1].reg_write && held[0].rt == held[1].rt;
    dual = state == ST_BOTH && (&ready) && held[0].pipe != held[1].pipe && !raw && !waw;

    iss = 2'b00;
    if (!flush) begin
      if (dual)          iss = 2'b11;
      else if (state[0]) iss[0] = ready[0];
      else if (state[1]) iss[1] = ready[1];
    end

    issue_even = (iss[0] && held[0].pipe == PIPE_EVEN) || (iss[1] && held[1].pipe == PIPE_EVEN);
    even_sel   = iss[1] && held[1].pipe == PIPE_EVEN;
    issue_odd  = (iss[0] && held[0].pipe == PIPE_ODD) || (iss[1] && held[1].pipe == PIPE_ODD);
    odd_sel    = iss[1] && held[1].pipe == PIPE_ODD;
    first_odd  = (&iss) && held[0].pipe == PIPE_ODD;
    stall      = !flush && state != ST_EMPTY && iss == 2'b00;
    pair_ready = !flush && ((state & ~iss) == 2'b00);
    accept     = pair_valid && pair_ready;

    state_nxt = state;
    if (flush)       state_nxt = ST_EMPTY;
    else if (accept) state_nxt = pend_e'(slot_valid);
    else             state_nxt = pend_e'(state & ~iss);

    for (int s = 0; s < 2; s++) begin
      ld_en[s]  = iss[s] && held[s].reg_write;
      ld_cnt[s] = CNT_W'(unit_lat(held[s].pipe, held[s].unit, LAT_TAB) - 4'd1);
    end
  end

  reg_scoreboard u_sb (
    .clk     (clk),
    .reset   (reset),
    .ld_en   (ld_en),
    .ld_rt   ({held[1].rt, held[0].rt}),
    .ld_cnt  (ld_cnt),
    .rd_src  ({held[1].src, held[0].src}),
    .rd_use  ({held[1].src_use, held[0].src_use}),
    .rd_rt   ({held[1].rt, held[0].rt}),
    .rd_wr   ({held[1].reg_write, held[0].reg_write}),
    .slot_ok (ready)
  );
endmodule

// File: tb/tb_issue_control.sv
// Directed cycle table plus randomized run against a cycle-stamp reference model.
module tb_issue_control;
  import issue_control_pkg::*;

  logic clk = 1'b0;
  logic reset, pair_valid, pair_ready, flush;
  logic [1:0] slot_valid, slot_pipe, slot_reg_write;
  logic [1:0][1:0] slot_unit;
  logic [1:0][6:0] slot_rt;
  logic [1:0][2:0][6:0] slot_src;
  logic [1:0][2:0] slot_src_use;
  logic issue_even, even_sel, issue_odd, odd_sel, first_odd, stall;

  always #5 clk = ~clk;

  issue_control dut (
    .clk(clk), .reset(reset), .pair_valid(pair_valid), .pair_ready(pair_ready),
    .slot_valid(slot_valid), .slot_pipe(slot_pipe), .slot_unit(slot_unit), .slot_rt(slot_rt),
    .slot_reg_write(slot_reg_write), .slot_src(slot_src), .slot_src_use(slot_src_use),
    .flush(flush), .issue_even(issue_even), .even_sel(even_sel), .issue_odd(issue_odd),
    .odd_sel(odd_sel), .first_odd(first_odd), .stall(stall)
  );

  typedef struct {
    bit rst, pv, fl, chk;
    logic [1:0] sv;
    slot_t s0, s1;
    logic [6:0] exp;  // {issue_even, even_sel, issue_odd, odd_sel, first_odd, stall, pair_ready}
  } vec_t;

  vec_t tbl[$];
  int n_tests = 0, n_fail = 0;

  // Reference model: a register is free from cycle avail[r] on.
  int avail[NUM_REGS];
  int cyc = 0;
  bit [1:0] pend;
  slot_t hs[2];
  int even_lat[4] = '{6, 4, 4, 2};
  int odd_lat[4]  = '{4, 6, 1, 1};

  function automatic slot_t S(bit p, int u, int rt, bit wr, int ra, int rb, int rc, logic [2:0] use_m);
    slot_t s;
    s.pipe = p; s.unit = 2'(u); s.rt = 7'(rt); s.reg_write = wr;
    s.src[0] = 7'(ra); s.src[1] = 7'(rb); s.src[2] = 7'(rc); s.src_use = use_m;
    return s;
  endfunction

  function automatic slot_t rnd_slot();
    return S(1'($urandom), int'($urandom_range(3)), int'($urandom_range(7)), 1'($urandom),
             int'($urandom_range(7)), int'($urandom_range(7)), int'($urandom_range(7)), 3'($urandom));
  endfunction

  function automatic void add(bit rst, bit pv, bit fl, bit chk, logic [1:0] sv, slot_t s0, slot_t s1, logic [6:0] e);
    vec_t v;
    v.rst = rst; v.pv = pv; v.fl = fl; v.chk = chk; v.sv = sv; v.s0 = s0; v.s1 = s1; v.exp = e;
    tbl.push_back(v);
  endfunction

  function automatic bit free(slot_t s);
    for (int k = 0; k < 3; k++) if (s.src_use[k] && avail[s.src[k]] > cyc) return 1'b0;
    return !(s.reg_write && avail[s.rt] > cyc);
  endfunction

  function automatic int mlat(slot_t s);
    return s.pipe ? odd_lat[s.unit] : even_lat[s.unit];
  endfunction

  task automatic model(input vec_t v, output logic [6:0] e, output bit i0, output bit i1, output bit pr);
    bit dual, dep, same_rt, ie, es, io, os, fo, st;
    dep = 1'b0;
    for (int k = 0; k < 3; k++)
      if (hs[0].reg_write && hs[1].src_use[k] && hs[1].src[k] == hs[0].rt) dep = 1'b1;
    same_rt = hs[0].reg_write && hs[1].reg_write && hs[0].rt == hs[1].rt;
    dual = pend == 2'b11 && free(hs[0]) && free(hs[1]) && hs[0].pipe != hs[1].pipe && !dep && !same_rt;
    i0 = 1'b0; i1 = 1'b0;
    if (!v.fl) begin
      if (dual)         begin i0 = 1'b1; i1 = 1'b1; end
      else if (pend[0]) i0 = free(hs[0]);
      else if (pend[1]) i1 = free(hs[1]);
    end
    ie = (i0 && !hs[0].pipe) || (i1 && !hs[1].pipe);
    es = i1 && !hs[1].pipe;
    io = (i0 && hs[0].pipe) || (i1 && hs[1].pipe);
    os = i1 && hs[1].pipe;
    fo = i0 && i1 && hs[0].pipe;
    st = !v.fl && pend != 2'b00 && !i0 && !i1;
    pr = !v.fl && !(pend[0] && !i0) && !(pend[1] && !i1);
    e = {ie, es, io, os, fo, st, pr};
  endtask

  task automatic run_cycle(input vec_t v, input bit use_model, input string nm);
    logic [6:0] e, got;
    bit i0, i1, pr;
    reset = v.rst; pair_valid = v.pv; flush = v.fl; slot_valid = v.sv;
    slot_pipe = {v.s1.pipe, v.s0.pipe};           slot_unit = {v.s1.unit, v.s0.unit};
    slot_rt = {v.s1.rt, v.s0.rt};                 slot_reg_write = {v.s1.reg_write, v.s0.reg_write};
    slot_src = {v.s1.src, v.s0.src};              slot_src_use = {v.s1.src_use, v.s0.src_use};
    @(negedge clk);
    e = v.exp; i0 = 1'b0; i1 = 1'b0; pr = 1'b0;
    if (use_model) model(v, e, i0, i1, pr);
    got = {issue_even, even_sel, issue_odd, odd_sel, first_odd, stall, pair_ready};
    if (v.chk) begin
      n_tests++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL %s: outputs {ie,es,io,os,fo,st,pr} got %b expected %b", nm, got, e);
      end
    end
    @(posedge clk);
    if (use_model) begin
      if (i0 && hs[0].reg_write) avail[hs[0].rt] = cyc + mlat(hs[0]);
      if (i1 && hs[1].reg_write) avail[hs[1].rt] = cyc + mlat(hs[1]);
      if (v.rst) begin
        pend = 2'b00;
        for (int r = 0; r < NUM_REGS; r++) avail[r] = 0;
      end else if (v.fl) pend = 2'b00;
      else begin
        pend = pend & ~{i1, i0};
        if (v.pv && pr) begin pend = v.sv; hs[0] = v.s0; hs[1] = v.s1; end
      end
      cyc++;
    end
    #1;
  endtask

  initial begin
    slot_t N;
    vec_t v;
    N = S(0, 0, 0, 0, 0, 0, 0, 3'b000);
    add(1, 0, 0, 0, 2'b00, N, N, 7'b0000000);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0000001);
    // FX1 even + LS odd: dual, no first_odd
    add(0, 1, 0, 1, 2'b11, S(0, 3, 5, 1, 0, 0, 0, 3'b000), S(1, 1, 0, 0, 7, 0, 0, 3'b001), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1011001);
    // Perm odd + FP even: dual, first_odd
    add(0, 1, 0, 1, 2'b11, S(1, 0, 10, 1, 1, 0, 0, 3'b001), S(0, 0, 11, 1, 2, 0, 0, 3'b001), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1110101);
    // two even FX1: serialised
    add(0, 1, 0, 1, 2'b11, S(0, 3, 20, 1, 21, 0, 0, 3'b001), S(0, 3, 22, 1, 23, 0, 0, 3'b001), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1000000);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1100001);
    // FP writes r3, odd reader of r3 waits six cycles
    add(0, 1, 0, 1, 2'b11, S(0, 0, 3, 1, 0, 0, 0, 3'b000), S(1, 1, 0, 0, 3, 0, 0, 3'b001), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1000000);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 2'b00, N, N, 7'b0000010);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0011001);
    // flush in first cycle of a serialised pair
    add(0, 1, 0, 1, 2'b11, S(0, 3, 30, 1, 0, 0, 0, 3'b000), S(0, 3, 31, 1, 0, 0, 0, 3'b000), 7'b0000001);
    add(0, 0, 1, 1, 2'b00, N, N, 7'b0000000);
    add(0, 1, 0, 1, 2'b11, S(1, 2, 0, 0, 0, 0, 0, 3'b000), S(0, 1, 0, 0, 0, 0, 0, 3'b000), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1110101);
    // set r9 busy (5), hold a pair reading r9, then reset
    add(0, 1, 0, 1, 2'b11, S(0, 3, 40, 1, 0, 0, 0, 3'b000), S(0, 0, 9, 1, 0, 0, 0, 3'b000), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1000000);
    add(0, 1, 0, 1, 2'b11, S(1, 1, 41, 1, 9, 0, 0, 3'b001), S(0, 3, 42, 1, 9, 0, 0, 3'b001), 7'b1100001);
    add(1, 0, 0, 1, 2'b00, N, N, 7'b0000010);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0000001);
    add(0, 1, 0, 1, 2'b11, S(1, 1, 41, 1, 9, 0, 0, 3'b001), S(0, 3, 42, 1, 9, 0, 0, 3'b001), 7'b0000001);
    // dual issue while accepting the next pair back to back
    add(0, 1, 0, 1, 2'b11, S(0, 1, 50, 1, 0, 0, 0, 3'b000), S(1, 0, 51, 1, 0, 0, 0, 3'b000), 7'b1110101);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1011001);
    // WAW on r60 across pipes
    add(0, 1, 0, 1, 2'b11, S(0, 3, 60, 1, 0, 0, 0, 3'b000), S(1, 1, 60, 1, 0, 0, 0, 3'b000), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b1000000);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0000010);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0011001);
    // empty pair, then slot-1-only pair
    add(0, 1, 0, 1, 2'b00, N, N, 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0000001);
    add(0, 1, 0, 1, 2'b10, N, S(1, 2, 0, 0, 0, 0, 0, 3'b000), 7'b0000001);
    add(0, 0, 0, 1, 2'b00, N, N, 7'b0011001);

    foreach (tbl[i]) run_cycle(tbl[i], 1'b0, $sformatf("vec%0d", i));

    pend = 2'b00;
    hs[0] = N; hs[1] = N;
    v = tbl[0];
    run_cycle(v, 1'b1, "rand_reset");
    for (int i = 0; i < 600; i++) begin
      v.rst = ($urandom_range(63) == 0);
      v.pv  = ($urandom_range(9) < 7);
      v.fl  = ($urandom_range(9) == 0);
      v.chk = 1'b1;
      v.sv  = 2'($urandom);
      v.s0  = rnd_slot();
      v.s1  = rnd_slot();
      run_cycle(v, 1'b1, $sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
